// File: rtl/tpu_pkg.sv
// tpu_pkg: shared defaults and writeback FSM state type for the TPU datapath.
package tpu_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} wb_state_t;
endpackage

// File: rtl/wb_lane_fifo.sv
// wb_lane_fifo: synchronous per-lane skew buffer (DEPTH a power of two, >= 2).
//   push/din  : write din at the tail when push is high
//   pop       : drop the head word; dout always shows the head
//   full/empty/count : occupancy; push and pop together on a full FIFO is legal
module wb_lane_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    always_comb begin
        wp_d  = push ? wp_q + PW'(1) : wp_q;
        rp_d  = pop ? rp_q + PW'(1) : rp_q;
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: only words between rp and wp are ever observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din;
    end
    assign dout  = mem_q[rp_q];
    assign full  = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/vpu_writeback.sv
// vpu_writeback: merges two VPU result lanes into interleaved unified-buffer writes.
//   start/base_addr/num_rows : arm a transfer of num_rows words per lane
//   vpu_data_in_N/vpu_valid_in_N : lane result words, buffered per lane
//   ub_wr_en/addr/data/ready : UB write handshake, commit on en && ready
//   busy/done/overflow : status; overflow is sticky until the next start
module vpu_writeback
    import tpu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [DATA_W-1:0] vpu_data_in_1,
    input  logic [DATA_W-1:0] vpu_data_in_2,
    input  logic              vpu_valid_in_1,
    input  logic              vpu_valid_in_2,
    output logic              ub_wr_en,
    output logic [ADDR_W-1:0] ub_wr_addr,
    output logic [DATA_W-1:0] ub_wr_data,
    input  logic              ub_wr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, rows_q, rows_d;
    logic [ADDR_W-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic [ADDR_W-1:0] wr1_q, wr1_d, wr2_q, wr2_d;
    logic              ptr_q, ptr_d, lock_q, lock_d, lock_lane_q, lock_lane_d;
    logic              ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

    logic [DATA_W-1:0] head1, head2;
    logic              full1, full2, empty1, empty2;
    logic [CW-1:0]     cnt1_unused, cnt2_unused;
    logic              run, en, sel, commit, last_commit;
    logic              push1, push2, pop1, pop2, drop1, drop2;
    logic [ADDR_W-1:0] row;

    wb_lane_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .push(push1), .pop(pop1), .din(vpu_data_in_1),
        .dout(head1), .full(full1), .empty(empty1), .count(cnt1_unused)
    );
    wb_lane_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk(clk), .rst_n(rst_n), .push(push2), .pop(pop2), .din(vpu_data_in_2),
        .dout(head2), .full(full2), .empty(empty2), .count(cnt2_unused)
    );

    always_comb begin
        run = state_q == RUN;
        // A stalled request keeps its lane so addr/data cannot change under it;
        // otherwise the pointer breaks ties and a lone non-empty lane wins.
        sel = lock_q ? lock_lane_q : (!empty1 && !empty2) ? ptr_q : empty1;
        en          = run && !(empty1 && empty2);
        commit      = en && ub_wr_ready;
        pop1        = commit && !sel;
        pop2        = commit && sel;
        push1       = run && vpu_valid_in_1 && acc1_q < rows_q && (!full1 || pop1);
        push2       = run && vpu_valid_in_2 && acc2_q < rows_q && (!full2 || pop2);
        drop1       = run && vpu_valid_in_1 && !push1;
        drop2       = run && vpu_valid_in_2 && !push2;
        row         = sel ? wr2_q : wr1_q;
        last_commit = commit && ({1'b0, wr1_q} + {1'b0, wr2_q} + (ADDR_W+1)'(1) == {rows_q, 1'b0});
        ub_wr_en    = en;
        ub_wr_addr  = en ? base_q + {row[ADDR_W-2:0], 1'b0} + ADDR_W'(sel) : '0;
        ub_wr_data  = en ? (sel ? head2 : head1) : '0;
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rows_d      = rows_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        wr1_d       = wr1_q;
        wr2_d       = wr2_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        lock_d      = en && !ub_wr_ready;
        lock_lane_d = sel;
        if (state_q == IDLE && start) begin
            base_d  = base_addr;
            rows_d  = num_rows;
            acc1_d  = '0;
            acc2_d  = '0;
            wr1_d   = '0;
            wr2_d   = '0;
            ptr_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = num_rows == '0 ? DONE : RUN;
        end else if (run) begin
            acc1_d  = acc1_q + ADDR_W'(push1);
            acc2_d  = acc2_q + ADDR_W'(push2);
            wr1_d   = wr1_q + ADDR_W'(pop1);
            wr2_d   = wr2_q + ADDR_W'(pop2);
            ptr_d   = commit ? !sel : ptr_q;
            ovf_d   = ovf_q || drop1 || drop2;
            state_d = last_commit ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            rows_q      <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            wr1_q       <= '0;
            wr2_q       <= '0;
            ptr_q       <= 1'b0;
            lock_q      <= 1'b0;
            lock_lane_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rows_q      <= rows_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            wr1_q       <= wr1_d;
            wr2_q       <= wr2_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_lane_q <= lock_lane_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_vpu_writeback.sv
// tb_vpu_writeback: directed bench with a queue-based reference model for vpu_writeback.
module tb_vpu_writeback;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEPTH = 4;

    logic          clk = 0, rst_n = 0, start = 0, ready = 0;
    logic [AW-1:0] base_addr = 0, num_rows = 0;
    logic [DW-1:0] d1 = 0, d2 = 0;
    logic          v1 = 0, v2 = 0;
    logic          ub_wr_en, busy, done, overflow;
    logic [AW-1:0] ub_wr_addr;
    logic [DW-1:0] ub_wr_data;

    vpu_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .vpu_data_in_1(d1), .vpu_data_in_2(d2), .vpu_valid_in_1(v1), .vpu_valid_in_2(v2),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
        .ub_wr_ready(ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 run, 2 done; one queue of pending words per lane.
    int            ms = 0, last = 1, hl = 0;
    bit            hold = 0, movf = 0;
    logic [AW-1:0] mbase = 0, mrows = 0;
    int            acc[2], wr[2];
    logic [DW-1:0] mq0[$], mq1[$];
    logic [AW+DW-1:0] dlog[$], exp_q[$];

    always @(negedge clk) begin : cmp
        int            l;
        bit            ee, commit;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (!rst_n) begin
            chk("rst_en", ub_wr_en, 0);
            chk("rst_addr", ub_wr_addr, 0);
            chk("rst_data", ub_wr_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ovf", overflow, 0);
            ms = 0; hold = 0; movf = 0;
            mq0.delete(); mq1.delete();
            acc = '{0, 0}; wr = '{0, 0};
        end else begin
            ee = ms == 1 && (mq0.size() > 0 || mq1.size() > 0);
            chk("wr_en", ub_wr_en, ee);
            chk("busy", busy, ms != 0);
            chk("done", done, ms == 2);
            chk("overflow", overflow, movf);
            l = 0; ea = 0; ed = 0;
            if (ee) begin
                if (hold) l = hl;
                else if (mq0.size() > 0 && mq1.size() > 0) l = 1 - last;
                else l = mq0.size() > 0 ? 0 : 1;
                ea = mbase + AW'(2 * wr[l] + l);
                ed = l == 1 ? mq1[0] : mq0[0];
                chk("wr_addr", ub_wr_addr, ea);
                chk("wr_data", ub_wr_data, ed);
            end
            if (ub_wr_en && ready) dlog.push_back({ub_wr_addr, ub_wr_data});
            if (ms == 0) begin
                hold = 0;
                if (start) begin
                    mbase = base_addr; mrows = num_rows; movf = 0; last = 1;
                    acc = '{0, 0}; wr = '{0, 0};
                    ms = num_rows == 0 ? 2 : 1;
                end
            end else if (ms == 2) begin
                ms = 0; hold = 0;
            end else begin
                commit = ee && ready;
                if (commit) begin
                    if (l == 0) mq0.delete(0); else mq1.delete(0);
                    wr[l]++;
                    last = l;
                end
                if (v1) begin
                    if (acc[0] < int'(mrows) && mq0.size() < DEPTH) begin mq0.push_back(d1); acc[0]++; end
                    else movf = 1;
                end
                if (v2) begin
                    if (acc[1] < int'(mrows) && mq1.size() < DEPTH) begin mq1.push_back(d2); acc[1]++; end
                    else movf = 1;
                end
                hold = ee && !ready;
                hl = l;
                if (wr[0] + wr[1] == 2 * int'(mrows)) ms = 2;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] n);
        dlog.delete();
        base_addr = b; num_rows = n; start = 1;
        cyc();
        start = 0;
    endtask

    task automatic lanes(input logic a, input logic [DW-1:0] x, input logic b, input logic [DW-1:0] y);
        v1 = a; d1 = x; v2 = b; d2 = y;
        cyc();
        v1 = 0; v2 = 0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100 && !done; i++) cyc();
        chk(name, done, 1);
        cyc();
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, dlog.size(), exp_q.size());
        foreach (exp_q[i]) if (i < dlog.size()) chk(name, dlog[i], exp_q[i]);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        repeat (2) cyc();
        chk("reset_en", ub_wr_en, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1;
        cyc();

        // Interleaving with lane 2 one cycle behind lane 1
        ready = 1;
        go(8'h10, 3);
        lanes(1, 1, 0, 0);
        lanes(1, 2, 1, 4);
        lanes(1, 3, 1, 5);
        lanes(0, 0, 1, 6);
        wait_done("s1_done");
        chk("s1_done_pulse", done, 0);
        exp_q = '{24'h100001, 24'h110004, 24'h120002, 24'h130005, 24'h140003, 24'h150006};
        chk_log("s1_log");

        // Backpressure: request must hold steady until ready rises
        ready = 0;
        go(8'h20, 2);
        lanes(1, 7, 1, 9);
        lanes(1, 8, 1, 10);
        repeat (3) cyc();
        chk("s2_hold_en", ub_wr_en, 1);
        chk("s2_hold_addr", ub_wr_addr, 8'h20);
        chk("s2_hold_data", ub_wr_data, 7);
        ready = 1;
        wait_done("s2_done");
        exp_q = '{24'h200007, 24'h210009, 24'h220008, 24'h23000A};
        chk_log("s2_log");
        chk("s2_ovf", overflow, 0);

        // Fifth word into a full lane FIFO is dropped and overflow sticks
        ready = 0;
        go(8'h30, 8);
        for (int i = 1; i <= 5; i++) lanes(1, DW'(i), 0, 0);
        chk("s3_ovf_set", overflow, 1);
        ready = 1;
        repeat (4) cyc();
        for (int i = 0; i < 8; i++) lanes(i < 4, DW'(6 + i), 1, DW'(16'h100 + i));
        wait_done("s3_done");
        chk("s3_ovf_sticky", overflow, 1);
        chk("s3_count", dlog.size(), 16);
        exp_q = '{24'h300001, 24'h320002, 24'h340003, 24'h360004,
                  24'h380006, 24'h3A0007, 24'h3C0008, 24'h3E0009};
        k = 0;
        foreach (dlog[i]) if (dlog[i][DW] == 1'b0 && k < 8) begin chk("s3_lane1", dlog[i], exp_q[k]); k++; end
        chk("s3_lane1_n", k, 8);

        // Address wrap-around; start also clears the sticky overflow
        go(8'hFE, 2);
        chk("s4_ovf_clr", overflow, 0);
        lanes(1, 16'h11, 1, 16'h21);
        lanes(1, 16'h12, 1, 16'h22);
        wait_done("s4_done");
        exp_q = '{24'hFE0011, 24'hFF0021, 24'h000012, 24'h010022};
        chk_log("s4_log");

        // Zero rows goes straight to done; a word beyond num_rows is dropped
        go(8'h50, 0);
        chk("s5_done", done, 1);
        chk("s5_busy", busy, 1);
        chk("s5_en", ub_wr_en, 0);
        cyc();
        chk("s5_idle_busy", busy, 0);
        go(8'h60, 1);
        lanes(1, 16'hAA, 0, 0);
        lanes(1, 16'hBB, 0, 0);
        chk("s5_ovf", overflow, 1);
        lanes(0, 0, 1, 16'hCC);
        wait_done("s5_done2");
        exp_q = '{24'h6000AA, 24'h6100CC};
        chk_log("s5_log");

        // Reset after two committed writes abandons the transfer
        go(8'h40, 3);
        lanes(1, 1, 1, 4);
        lanes(1, 2, 1, 5);
        v1 = 1; d1 = 3; v2 = 1; d2 = 6;
        cyc();
        chk("s6_two_writes", dlog.size(), 2);
        rst_n = 0; v1 = 0; v2 = 0;
        #1;
        chk("s6_rst_en", ub_wr_en, 0);
        chk("s6_rst_addr", ub_wr_addr, 0);
        chk("s6_rst_data", ub_wr_data, 0);
        chk("s6_rst_busy", busy, 0);
        repeat (2) cyc();
        rst_n = 1;
        cyc();
        chk("s6_post_en", ub_wr_en, 0);
        chk("s6_post_busy", busy, 0);
        go(8'h40, 3);
        lanes(1, 1, 1, 4);
        lanes(1, 2, 1, 5);
        lanes(1, 3, 1, 6);
        wait_done("s6_done");
        exp_q = '{24'h400001, 24'h410004, 24'h420002, 24'h430005, 24'h440003, 24'h450006};
        chk_log("s6_log");

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vpu_writeback.md
VPU_WRITEBACK -- requirements
Module: vpu_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed word width of each lane.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning unified-buffer address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning per-lane skew buffer depth (power of two).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  meaning one-cycle pulse that arms a transfer.
REQ-007 SHALL have port base_addr  input  ADDR_W  meaning first UB address, sampled on start.
REQ-008 SHALL have port num_rows  input  ADDR_W  meaning rows expected per lane, sampled on start.
REQ-009 SHALL have ports vpu_data_in_1/vpu_data_in_2  input  DATA_W each  meaning VPU lane results.
REQ-010 SHALL have ports vpu_valid_in_1/vpu_valid_in_2  input  1 each  meaning lane word valid.
REQ-011 SHALL have port ub_wr_en  output  1  meaning UB write request.
REQ-012 SHALL have port ub_wr_addr  output  ADDR_W  meaning UB write address.
REQ-013 SHALL have port ub_wr_data  output  DATA_W  meaning UB write data.
REQ-014 SHALL have port ub_wr_ready  input  1  meaning UB accepts the write this cycle.
REQ-015 SHALL have ports busy, done, overflow  output  1 each  meaning transfer active, one-cycle completion pulse, sticky drop error.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when 2*num_rows writes are committed, DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL go IDLE->DONE directly when start arrives with num_rows==0, issuing no writes.
REQ-018 SHALL ignore start outside IDLE and ignore lane valids in IDLE and DONE.
REQ-019 SHALL assert busy exactly in RUN and DONE, and done exactly in DONE.
REQ-020 SHALL push a lane word into that lane's FIFO on valid in RUN while the lane's accepted count < num_rows.
REQ-021 SHALL drop a lane word and set overflow when its valid arrives with the lane's accepted count == num_rows, or with the FIFO full and no pop that cycle; push on full with simultaneous pop SHALL succeed.
REQ-022 SHALL address row r of lane 1 at base_addr+2r and of lane 2 at base_addr+2r+1, modulo 2^ADDR_W (wrap-around silent).
REQ-023 SHALL commit a write only when ub_wr_en and ub_wr_ready are both high; ub_wr_addr/ub_wr_data SHALL hold stable while ub_wr_en is high and not accepted.
REQ-024 SHALL issue at most one write per cycle, arbitrating round-robin between non-empty lanes, lane 1 first after each start; a lone non-empty lane wins.
REQ-025 SHALL have minimum latency one cycle: valid at edge t, ub_wr_en high after edge t (ready permitting), writes registered.
REQ-026 SHALL preserve per-lane order; lane 2 lagging lane 1 by any number of cycles up to FIFO_DEPTH SHALL not lose data.
REQ-027 SHALL clear overflow on accepted start; otherwise overflow holds until reset.

Reset
REQ-028 SHALL, while rst_n low, force FSM IDLE, FIFOs empty, counters zero, and ub_wr_en, ub_wr_addr, ub_wr_data, busy, done, overflow all zero.
REQ-029 SHALL abandon any in-flight transfer on reset mid-RUN without completing partial writes; first post-reset cycle sees ub_wr_en low.

Structure
REQ-030 SHALL take DATA_W, ADDR_W defaults and the wb_state_t enum (IDLE, RUN, DONE) from the shared tpu_pkg package.
REQ-031 SHALL instantiate sub-module wb_lane_fifo (synchronous FIFO with push, pop, full, empty, count) once per lane.

Verification
REQ-032 SHALL cover: base_addr=0x10, num_rows=3, lane1 {1,2,3} on cycles 1-3, lane2 {4,5,6} on cycles 2-4, ready=1 -> six writes 0x10..0x15 = 1,4,2,5,3,6, then one-cycle done.
REQ-033 SHALL cover: num_rows=2, ready low 5 cycles after first valid -> ub_wr_en held with addr/data stable, all four writes land once ready rises, overflow=0.
REQ-034 SHALL cover: FIFO_DEPTH=4, ready=0, lane1 valid 5 consecutive cycles with num_rows=8 -> fifth word dropped, overflow=1, remains 1 until next start.
REQ-035 SHALL cover: base_addr=0xFE, num_rows=2 -> addresses 0xFE,0xFF,0x00,0x01.
REQ-036 SHALL cover: start with num_rows=0 -> done pulse next cycle, no ub_wr_en; extra valid after count reached -> overflow=1.
REQ-037 SHALL cover: rst_n low mid-RUN after two of six writes -> all outputs zero immediately, IDLE; fresh start completes normally.
